// File: rtl/serialtopara.sv
// Dual-lane serial-to-parallel receiver: comma word alignment,
// deserialization and a show-ahead FIFO per lane.
`timescale 1ns/1ps

module serialtopara_lane #(
    parameter int          DATA_SIZE   = 8,
    parameter logic [DATA_SIZE-1:0] COMMA = 8'hBC,
    parameter int          LOCK_COUNT  = 4,
    parameter int          FIFO_DEPTH  = 4,
    parameter int          ALMOST_FULL = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_in,
    input  logic                 i_pop,
    output logic [DATA_SIZE-1:0] o_out,
    output logic                 o_empty,
    output logic                 o_afull,
    output logic                 o_active,
    output logic                 o_error
);

    localparam int BW = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
    localparam int LW = $clog2(LOCK_COUNT + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        HUNT,
        ALIGN,
        ACTIVE
    } state_t;

    state_t               r_state;
    state_t               w_state_n;
    logic [DATA_SIZE-1:0] r_sr;
    logic [BW-1:0]        r_bitcnt;
    logic [BW-1:0]        w_bitcnt_n;
    logic [BW-1:0]        w_bit_inc;
    logic [LW-1:0]        r_cc;
    logic [LW-1:0]        w_cc_n;
    logic [DATA_SIZE-1:0] w_nxt;
    logic                 w_is_comma;
    logic                 w_bound;
    logic                 w_push;

    logic [DATA_SIZE-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]        r_wr;
    logic [PW-1:0]        r_rd;
    logic [CW-1:0]        r_count;
    logic [CW-1:0]        w_count_n;
    logic [DATA_SIZE-1:0] r_out;
    logic [DATA_SIZE-1:0] w_out_n;
    logic                 r_empty;
    logic                 r_afull;
    logic                 r_error;
    logic                 w_full;
    logic                 w_can_pop;
    logic                 w_pop_err;
    logic                 w_wr;
    logic                 w_ovf;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_nxt      = {r_sr[DATA_SIZE-2:0], i_in};
    assign w_is_comma = (w_nxt == COMMA);
    assign w_bound    = (r_bitcnt == BW'(DATA_SIZE - 1));
    assign w_bit_inc  = w_bound ? '0 : r_bitcnt + BW'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= HUNT;
            r_sr     <= '0;
            r_bitcnt <= '0;
            r_cc     <= '0;
        end else begin
            r_state  <= w_state_n;
            r_sr     <= w_nxt;
            r_bitcnt <= w_bitcnt_n;
            r_cc     <= w_cc_n;
        end
    end

    // Alignment: any bit position in HUNT, word boundaries only afterwards
    always_comb begin
        w_state_n  = r_state;
        w_bitcnt_n = r_bitcnt;
        w_cc_n     = r_cc;
        w_push     = 1'b0;
        unique case (r_state)
            HUNT: begin
                w_bitcnt_n = '0;
                if (w_is_comma) begin
                    w_cc_n    = LW'(1);
                    w_state_n = ALIGN;
                end
            end
            ALIGN: begin
                w_bitcnt_n = w_bit_inc;
                if (w_bound) begin
                    if (w_is_comma) begin
                        w_cc_n = r_cc + LW'(1);
                        if (r_cc == LW'(LOCK_COUNT - 1)) begin
                            w_state_n = ACTIVE;
                        end
                    end else begin
                        w_cc_n    = '0;
                        w_state_n = HUNT;
                    end
                end
            end
            ACTIVE: begin
                w_bitcnt_n = w_bit_inc;
                if (w_bound && !w_is_comma) begin
                    w_push = 1'b1;
                end
            end
            default: begin
                w_state_n  = HUNT;
                w_bitcnt_n = '0;
                w_cc_n     = '0;
            end
        endcase
    end

    assign w_full    = (r_count == CW'(FIFO_DEPTH));
    assign w_can_pop = i_pop && (r_count != '0);
    assign w_pop_err = i_pop && (r_count == '0);
    // A pop at full frees the slot the incoming word lands in
    assign w_wr      = w_push && (!w_full || w_can_pop);
    assign w_ovf     = w_push && w_full && !w_can_pop;

    always_comb begin
        w_count_n = r_count;
        if (w_wr && !w_can_pop) begin
            w_count_n = r_count + CW'(1);
        end else if (!w_wr && w_can_pop) begin
            w_count_n = r_count - CW'(1);
        end
    end

    // Registered head copy so the last word is held once drained
    always_comb begin
        w_out_n = r_out;
        if (w_can_pop && (r_count > CW'(1))) begin
            w_out_n = r_mem[f_inc(r_rd)];
        end else if (w_wr && (r_count == '0 ||
                     (w_can_pop && r_count == CW'(1)))) begin
            w_out_n = w_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr] <= w_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_out   <= '0;
            r_empty <= 1'b1;
            r_afull <= 1'b0;
            r_error <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr <= f_inc(r_wr);
            end
            if (w_can_pop) begin
                r_rd <= f_inc(r_rd);
            end
            r_count <= w_count_n;
            r_out   <= w_out_n;
            r_empty <= (w_count_n == '0);
            r_afull <= (w_count_n >= CW'(ALMOST_FULL));
            r_error <= r_error | w_pop_err | w_ovf;
        end
    end

    assign o_out    = r_out;
    assign o_empty  = r_empty;
    assign o_afull  = r_afull;
    assign o_active = (r_state == ACTIVE);
    assign o_error  = r_error;

endmodule

module serialtopara #(
    parameter int          DATA_SIZE   = 8,
    parameter logic [DATA_SIZE-1:0] COMMA = 8'hBC,
    parameter int          LOCK_COUNT  = 4,
    parameter int          FIFO_DEPTH  = 4,
    parameter int          ALMOST_FULL = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in0,
    input  logic                 in1,
    input  logic                 pop_0,
    input  logic                 pop_1,
    output logic [DATA_SIZE-1:0] out0,
    output logic [DATA_SIZE-1:0] out1,
    output logic                 fifo_empty0,
    output logic                 fifo_empty1,
    output logic                 fifo0_almostfull,
    output logic                 fifo1_almostfull,
    output logic                 active0,
    output logic                 active1,
    output logic                 Error0,
    output logic                 Error1
);

    serialtopara_lane #(
        .DATA_SIZE  (DATA_SIZE),
        .COMMA      (COMMA),
        .LOCK_COUNT (LOCK_COUNT),
        .FIFO_DEPTH (FIFO_DEPTH),
        .ALMOST_FULL(ALMOST_FULL)
    ) u_lane0 (
        .clk     (clk),
        .reset   (reset),
        .i_in    (in0),
        .i_pop   (pop_0),
        .o_out   (out0),
        .o_empty (fifo_empty0),
        .o_afull (fifo0_almostfull),
        .o_active(active0),
        .o_error (Error0)
    );

    serialtopara_lane #(
        .DATA_SIZE  (DATA_SIZE),
        .COMMA      (COMMA),
        .LOCK_COUNT (LOCK_COUNT),
        .FIFO_DEPTH (FIFO_DEPTH),
        .ALMOST_FULL(ALMOST_FULL)
    ) u_lane1 (
        .clk     (clk),
        .reset   (reset),
        .i_in    (in1),
        .i_pop   (pop_1),
        .o_out   (out1),
        .o_empty (fifo_empty1),
        .o_afull (fifo1_almostfull),
        .o_active(active1),
        .o_error (Error1)
    );

endmodule

// File: tb/tb_serialtopara.sv
// Directed bench for serialtopara: scoreboard queues per lane,
// checked by a monitor whenever a non-empty FIFO head is popped.
`timescale 1ns/1ps

module tb_serialtopara;

    localparam logic [7:0] K = 8'hBC;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in0 = 1'b0;
    logic       in1 = 1'b0;
    logic       pop_0 = 1'b0;
    logic       pop_1 = 1'b0;
    logic [7:0] out0;
    logic [7:0] out1;
    logic       fifo_empty0;
    logic       fifo_empty1;
    logic       fifo0_almostfull;
    logic       fifo1_almostfull;
    logic       active0;
    logic       active1;
    logic       Error0;
    logic       Error1;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    serialtopara dut (
        .clk             (clk),
        .reset           (reset),
        .in0             (in0),
        .in1             (in1),
        .pop_0           (pop_0),
        .pop_1           (pop_1),
        .out0            (out0),
        .out1            (out1),
        .fifo_empty0     (fifo_empty0),
        .fifo_empty1     (fifo_empty1),
        .fifo0_almostfull(fifo0_almostfull),
        .fifo1_almostfull(fifo1_almostfull),
        .active0         (active0),
        .active1         (active1),
        .Error0          (Error0),
        .Error1          (Error1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // One bit per lane per edge; inputs change 1ns after the edge
    task automatic cyc(input logic b0, input logic b1,
                       input logic p0, input logic p1);
        in0   = b0;
        in1   = b1;
        pop_0 = p0;
        pop_1 = p1;
        @(posedge clk);
        #1;
    endtask

    task automatic word(input logic [7:0] w0, input logic [7:0] w1,
                        input int p0s, input int p0n,
                        input int p1s, input int p1n);
        for (int i = 0; i < 8; i++) begin
            cyc(w0[7-i], w1[7-i],
                (i >= p0s) && (i < p0s + p0n),
                (i >= p1s) && (i < p1s + p1n));
        end
        pop_0 = 1'b0;
        pop_1 = 1'b0;
    endtask

    task automatic w0(input logic [7:0] w);
        word(w, 8'h00, 0, 0, 0, 0);
    endtask

    task automatic lock0();
        for (int i = 0; i < 4; i++) begin
            w0(K);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("rst_out0", out0, 0);
        chk("rst_out1", out1, 0);
        chk("rst_empty0", fifo_empty0, 1);
        chk("rst_empty1", fifo_empty1, 1);
        chk("rst_afull0", fifo0_almostfull, 0);
        chk("rst_afull1", fifo1_almostfull, 0);
        chk("rst_active0", active0, 0);
        chk("rst_active1", active1, 0);
        chk("rst_err0", Error0, 0);
        chk("rst_err1", Error1, 0);
        q0.delete();
        q1.delete();
        in0   = 1'b0;
        in1   = 1'b0;
        pop_0 = 1'b0;
        pop_1 = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin : monitor
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                if (pop_0 === 1'b1 && fifo_empty0 === 1'b0) begin
                    if (q0.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL mon0_extra: got %0h want none", out0);
                    end else begin
                        e = q0.pop_front();
                        chk("mon0_data", out0, e);
                    end
                end
                if (pop_1 === 1'b1 && fifo_empty1 === 1'b0) begin
                    if (q1.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL mon1_extra: got %0h want none", out1);
                    end else begin
                        e = q1.pop_front();
                        chk("mon1_data", out1, e);
                    end
                end
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // lock then data
        for (int i = 0; i < 3; i++) begin
            w0(K);
        end
        chk("t2_active0_b24", active0, 0);
        w0(K);
        chk("t2_active0_b32", active0, 1);
        chk("t2_empty0_b32", fifo_empty0, 1);
        q0.push_back(8'h5A);
        w0(8'h5A);
        chk("t2_empty0_b40", fifo_empty0, 0);
        chk("t2_out0_b40", out0, 8'h5A);
        chk("t2_active1", active1, 0);
        chk("t2_empty1", fifo_empty1, 1);
        word(K, 8'h00, 0, 1, 0, 0);
        chk("t2_empty0_pop", fifo_empty0, 1);
        chk("t2_out0_hold", out0, 8'h5A);
        chk("t2_err0", Error0, 0);

        // bit slip
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            w0(K);
        end
        chk("t3_active0_b27", active0, 0);
        w0(K);
        chk("t3_active0_b35", active0, 1);
        q0.push_back(8'h3C);
        w0(8'h3C);
        chk("t3_out0_b43", out0, 8'h3C);
        chk("t3_empty0_b43", fifo_empty0, 0);
        word(K, 8'h00, 0, 1, 0, 0);
        chk("t3_empty0_pop", fifo_empty0, 1);

        // broken lock
        do_reset();
        w0(K);
        w0(K);
        chk("t4_active0_b16", active0, 0);
        w0(8'h11);
        chk("t4_active0_b24", active0, 0);
        for (int i = 0; i < 3; i++) begin
            w0(K);
            chk("t4_active0_relock", active0, 0);
        end
        w0(K);
        chk("t4_active0_b56", active0, 1);
        w0(K);
        w0(K);
        chk("t4_idle_not_pushed", fifo_empty0, 1);
        q0.push_back(8'h42);
        w0(8'h42);
        chk("t4_out0", out0, 8'h42);
        word(K, 8'h00, 0, 1, 0, 0);
        chk("t4_empty0_pop", fifo_empty0, 1);

        // lane 1 independence
        do_reset();
        for (int i = 0; i < 4; i++) begin
            word(8'h00, K, 0, 0, 0, 0);
        end
        chk("l1_active1", active1, 1);
        chk("l1_active0", active0, 0);
        q1.push_back(8'hA5);
        word(8'h00, 8'hA5, 0, 0, 0, 0);
        chk("l1_out1", out1, 8'hA5);
        chk("l1_empty1", fifo_empty1, 0);
        chk("l1_empty0", fifo_empty0, 1);
        word(8'h00, K, 0, 0, 0, 1);
        chk("l1_empty1_pop", fifo_empty1, 1);
        word(8'h00, K, 0, 0, 0, 1);
        chk("l1_err1", Error1, 1);
        chk("l1_err0", Error0, 0);

        // overflow and backpressure
        do_reset();
        lock0();
        for (int k = 1; k <= 5; k++) begin
            if (k <= 4) begin
                q0.push_back(8'(k));
            end
            w0(8'(k));
            if (k == 2) chk("t5_afull_2", fifo0_almostfull, 0);
            if (k == 3) chk("t5_afull_3", fifo0_almostfull, 1);
            if (k == 4) chk("t5_err_4", Error0, 0);
        end
        chk("t5_err_ovf", Error0, 1);
        chk("t5_out0_head", out0, 8'h01);
        word(K, 8'h00, 0, 4, 0, 0);
        chk("t5_empty_4pop", fifo_empty0, 1);
        chk("t5_afull_4pop", fifo0_almostfull, 0);
        chk("t5_out0_hold", out0, 8'h04);
        word(K, 8'h00, 0, 1, 0, 0);
        chk("t5_err_extra", Error0, 1);
        chk("t5_empty_extra", fifo_empty0, 1);
        chk("t5_out0_extra", out0, 8'h04);

        // simultaneous push and pop at full, then mid-word reset
        do_reset();
        lock0();
        for (int k = 1; k <= 4; k++) begin
            q0.push_back(8'(k * 16));
            w0(8'(k * 16));
        end
        chk("t6_afull_full", fifo0_almostfull, 1);
        q0.push_back(8'h77);
        word(8'h77, 8'h00, 7, 1, 0, 0);
        chk("t6_err0", Error0, 0);
        chk("t6_afull", fifo0_almostfull, 1);
        chk("t6_out0", out0, 8'h20);
        word(K, 8'h00, 0, 3, 0, 0);
        chk("t6_empty_3pop", fifo_empty0, 0);
        chk("t6_out0_last", out0, 8'h77);
        word(K, 8'h00, 0, 1, 0, 0);
        chk("t6_empty_4pop", fifo_empty0, 1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            w0(K);
        end
        chk("t6_relock_3", active0, 0);
        w0(K);
        chk("t6_relock_4", active0, 1);

        repeat (2) @(posedge clk);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
